// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencer with lock qualification and downstream reset release
module pll_lock_supervisor #(
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 27000,
    parameter int MAX_RETRIES         = 8,
    parameter int CNT_W               = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic       fail,
    output logic [7:0] relock_count
);

    localparam int RET_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RET_W-1:0] RETRY_MAX    = RET_W'(MAX_RETRIES);
    localparam logic [RET_W-1:0] RETRY_LAST   = RET_W'(MAX_RETRIES - 1);

    typedef enum logic [1:0] {
        ST_PLLRST = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STABLE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             lock_meta_q, lock_meta_d;
    logic             lock_s_q, lock_s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RET_W-1:0] retries_q, retries_d;
    logic             fail_q, fail_d;
    logic [7:0]       relock_count_q, relock_count_d;
    logic             pll_reset_q, pll_reset_d;
    logic             sys_reset_q, sys_reset_d;
    logic             ready_q, ready_d;

    logic             state_entry;
    logic             lock_timeout;
    logic             lock_lost;
    logic             run_entry;

    // Two-stage synchronizer inputs for the asynchronous PLL lock
    always_comb begin
        lock_meta_d = pll_lock;
        lock_s_d    = lock_meta_q;
    end

    // Synchronizer flops; cleared so a reset always starts from "not locked"
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_PLLRST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; restart overrides every other transition
    always_comb begin
        state_d      = state_q;
        state_entry  = 1'b0;
        lock_timeout = 1'b0;
        lock_lost    = 1'b0;
        if (restart) begin
            state_d     = ST_PLLRST;
            state_entry = 1'b1;
        end else begin
            case (state_q)
                ST_PLLRST: begin
                    if (cnt_q == PLLRST_LAST) begin
                        state_d     = ST_WAIT;
                        state_entry = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (lock_s_q) begin
                        state_d     = ST_STABLE;
                        state_entry = 1'b1;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d      = ST_PLLRST;
                        state_entry  = 1'b1;
                        lock_timeout = 1'b1;
                    end
                end
                ST_STABLE: begin
                    // Lock dropping wins over the qualification reaching its end
                    if (!lock_s_q) begin
                        state_d     = ST_WAIT;
                        state_entry = 1'b1;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d     = ST_RUN;
                        state_entry = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s_q) begin
                        state_d     = ST_PLLRST;
                        state_entry = 1'b1;
                        lock_lost   = 1'b1;
                    end
                end
                default: begin
                    state_d     = ST_PLLRST;
                    state_entry = 1'b1;
                end
            endcase
        end
        run_entry = (state_d == ST_RUN) && (state_q != ST_RUN);
    end

    // Shared cycle counter, retry tracking and lock-loss statistics
    always_comb begin
        cnt_d          = cnt_q;
        retries_d      = retries_q;
        fail_d         = fail_q;
        relock_count_d = relock_count_q;

        // Counter restarts on every entry and is frozen in RUN where it is unused
        if (state_entry) begin
            cnt_d = '0;
        end else if (state_q != ST_RUN) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (run_entry) begin
            retries_d = '0;
            fail_d    = 1'b0;
        end else if (lock_timeout) begin
            if (retries_q != RETRY_MAX) begin
                retries_d = retries_q + 1'b1;
            end
            if (retries_q >= RETRY_LAST) begin
                fail_d = 1'b1;
            end
        end

        if (lock_lost && (relock_count_q != 8'hFF)) begin
            relock_count_d = relock_count_q + 8'd1;
        end
    end

    // Output decode from the next state so outputs change on the same edge as the state
    always_comb begin
        pll_reset_d = (state_d == ST_PLLRST);
        sys_reset_d = (state_d != ST_RUN);
        ready_d     = (state_d == ST_RUN);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            retries_q      <= '0;
            fail_q         <= 1'b0;
            relock_count_q <= 8'd0;
            pll_reset_q    <= 1'b1;
            sys_reset_q    <= 1'b1;
            ready_q        <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            retries_q      <= retries_d;
            fail_q         <= fail_d;
            relock_count_q <= relock_count_d;
            pll_reset_q    <= pll_reset_d;
            sys_reset_q    <= sys_reset_d;
            ready_q        <= ready_d;
        end
    end

    assign pll_reset    = pll_reset_q;
    assign sys_reset    = sys_reset_q;
    assign ready        = ready_q;
    assign fail         = fail_q;
    assign relock_count = relock_count_q;

endmodule
